// File: rtl/puf_challenge_sequencer.sv
// Arbiter-PUF challenge sequencer: walks RESP_BITS consecutive challenges from a seed and packs the decisions LSB first.
// Optional FIRE watchdog and sticky timeout_o flag are compiled in when PUF_TIMEOUT_EN is defined.
module puf_challenge_sequencer #(
`ifdef PUF_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 64,
`endif
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned RESP_BITS      = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [7:0]           seed_challenge_i,
    output logic [7:0]           puf_challenge_o,
    output logic                 puf_pulse_o,
    output logic                 puf_reset_o,
    input  logic                 puf_result_i,
    input  logic                 puf_done_i,
    output logic [RESP_BITS-1:0] response_o,
    output logic                 response_valid_o,
`ifdef PUF_TIMEOUT_EN
    output logic                 timeout_o,
`endif
    output logic                 busy_o
);

    localparam int unsigned IW = $clog2(RESP_BITS + 1);
`ifdef PUF_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_SETTLE, S_FIRE, S_CAPTURE, S_FINISH
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             chal_q, chal_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d, idx_inc;
    logic [RESP_BITS-1:0]   resp_q, resp_d;
    logic                   cap_bit;
`ifdef PUF_TIMEOUT_EN
    logic [TW-1:0]          wait_q, wait_d;
    logic                   timeout_q, timeout_d;
    logic                   tmo_hit_q, tmo_hit_d;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            chal_q    <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            resp_q    <= '0;
`ifdef PUF_TIMEOUT_EN
            wait_q    <= '0;
            timeout_q <= 1'b0;
            tmo_hit_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            chal_q    <= chal_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            resp_q    <= resp_d;
`ifdef PUF_TIMEOUT_EN
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            tmo_hit_q <= tmo_hit_d;
`endif
        end
    end

    always_comb begin
        state_d          = state_q;
        chal_d           = chal_q;
        cnt_d            = cnt_q;
        idx_d            = idx_q;
        resp_d           = resp_q;
        idx_inc          = idx_q + 1'b1;
        puf_pulse_o      = 1'b0;
        puf_reset_o      = 1'b0;
        response_valid_o = 1'b0;
        busy_o           = 1'b1;
`ifdef PUF_TIMEOUT_EN
        wait_d           = '0;
        timeout_d        = timeout_q;
        tmo_hit_d        = tmo_hit_q;
        // A timed-out challenge records 0 regardless of what the arbiter shows.
        cap_bit          = puf_result_i & ~tmo_hit_q;
`else
        cap_bit          = puf_result_i;
`endif

        case (state_q)
            S_IDLE: begin
                busy_o      = 1'b0;
                puf_reset_o = 1'b1;
                if (start_i) begin
                    chal_d    = seed_challenge_i;
                    cnt_d     = '0;
                    idx_d     = '0;
                    resp_d    = '0;
`ifdef PUF_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                    state_d   = S_ARM;
                end
            end
            S_ARM: begin
                puf_reset_o = 1'b1;
                if (cnt_q == 8'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == 8'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FIRE;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            S_FIRE: begin
                puf_pulse_o = 1'b1;
                if (puf_done_i) begin
                    state_d = S_CAPTURE;
`ifdef PUF_TIMEOUT_EN
                end else if (wait_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    tmo_hit_d = 1'b1;
                    state_d   = S_CAPTURE;
                end else begin
                    wait_d = wait_q + 1'b1;
`endif
                end
            end
            S_CAPTURE: begin
                for (int i = 0; i < int'(RESP_BITS); i++) begin
                    if (idx_q == IW'(i)) begin
                        resp_d[i] = cap_bit;
                    end
                end
                idx_d = idx_inc;
`ifdef PUF_TIMEOUT_EN
                tmo_hit_d = 1'b0;
`endif
                if (idx_inc < IW'(RESP_BITS)) begin
                    chal_d  = chal_q + 8'd1;
                    state_d = S_ARM;
                end else begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                puf_reset_o      = 1'b1;
                response_valid_o = 1'b1;
                state_d          = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign puf_challenge_o = chal_q;
    assign response_o      = resp_q;
`ifdef PUF_TIMEOUT_EN
    assign timeout_o       = timeout_q;
`endif

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Directed bench for puf_challenge_sequencer with a behavioural arbiter model and a timing monitor.
// Timeout scenario is compiled only when PUF_TIMEOUT_EN is defined.
module tb_puf_challenge_sequencer;

    localparam int SETTLE = 4;
    localparam int NBITS  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [7:0]       seed;
    logic [7:0]       chal;
    logic             pulse;
    logic             preset;
    logic             result;
    logic             done;
    logic [NBITS-1:0] resp;
    logic             valid;
    logic             busy;
`ifdef PUF_TIMEOUT_EN
    logic             tmo;
`endif

    puf_challenge_sequencer dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .seed_challenge_i (seed),
        .puf_challenge_o  (chal),
        .puf_pulse_o      (pulse),
        .puf_reset_o      (preset),
        .puf_result_i     (result),
        .puf_done_i       (done),
        .response_o       (resp),
        .response_valid_o (valid),
`ifdef PUF_TIMEOUT_EN
        .timeout_o        (tmo),
`endif
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    // Arbiter model: decision bit is a function of the applied challenge.
    int         mode_v     = 0;
    int         delay_v    = 0;
    bit         withhold_v = 1'b0;
    logic [7:0] seed_v     = 8'h00;

    function automatic logic model_bit(int m, logic [7:0] c);
        case (m)
            0:       return c[0];
            1:       return c[1];
            default: return ^c;
        endcase
    endfunction

    int fire_cnt = 0;
    int ridx     = 0;
    assign result = model_bit(mode_v, chal);
    assign done   = pulse && (fire_cnt > delay_v) && !(withhold_v && ridx == 4);

    // Monitor: free-running statistics, diffed by the test around each run.
    int         cyc = 0, rh = 0, rl = 0, rises = 0;
    int         rh_bad = 0, rl_bad = 0, chal_bad = 0, vcount = 0, vcyc = 0;
    logic       prev_reset = 1'b0, prev_pulse = 1'b0;
    logic [7:0] prev_chal = 8'h00;

    always @(negedge clk) begin
        cyc        <= cyc + 1;
        prev_reset <= preset;
        prev_pulse <= pulse;
        prev_chal  <= chal;
        fire_cnt   <= pulse ? fire_cnt + 1 : 0;
        rh         <= (busy && preset) ? rh + 1 : 0;
        rl         <= (busy && !preset && !pulse) ? rl + 1 : 0;
        if (busy && !preset && prev_reset && rh != SETTLE)
            rh_bad <= rh_bad + 1;
        if (!busy) begin
            ridx <= 0;
        end else if (pulse && !prev_pulse) begin
            rises <= rises + 1;
            ridx  <= ridx + 1;
            if (rl != SETTLE)
                rl_bad <= rl_bad + 1;
            if (chal != 8'(seed_v + 8'(ridx)))
                chal_bad <= chal_bad + 1;
        end else if (pulse && prev_pulse && chal != prev_chal) begin
            chal_bad <= chal_bad + 1;
        end
        if (valid) begin
            vcount <= vcount + 1;
            vcyc   <= cyc;
        end
    end

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] s);
        @(posedge clk);
        #1;
        seed  = s;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic run(input logic [7:0] s, input int m, input int d, input bit wh,
                       input logic [31:0] exp_resp, input int exp_lat);
        int v0, r0, h0, l0, c0, t0;
        v0 = vcount; r0 = rises; h0 = rh_bad; l0 = rl_bad; c0 = chal_bad;
        mode_v = m; delay_v = d; withhold_v = wh; seed_v = s;
        @(posedge clk);
        #1;
        seed  = s;
        start = 1'b1;
        t0    = cyc;
        tick(1);
        start = 1'b0;
        for (int k = 0; k < 3000 && vcount == v0; k++) tick(1);
        tick(3);
        check("response", resp, exp_resp);
        check("valid_pulses", vcount - v0, 1);
        check("latency", vcyc - t0, exp_lat);
        check("fire_count", rises - r0, NBITS);
        check("arm_len_errs", rh_bad - h0, 0);
        check("settle_len_errs", rl_bad - l0, 0);
        check("chal_seq_errs", chal_bad - c0, 0);
        check("busy_after", busy, 0);
        withhold_v = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  seed;
        int          mode;
        int          delay;
        logic [15:0] exp_resp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int v0, r0;
        vecs[0] = '{8'h10, 0, 0, 16'hAAAA};
        vecs[1] = '{8'h11, 0, 2, 16'h5555};
        vecs[2] = '{8'h00, 1, 1, 16'hCCCC};
        vecs[3] = '{8'hFE, 1, 0, 16'h3333};
        vecs[4] = '{8'h00, 2, 3, 16'h6996};
        vecs[5] = '{8'hFF, 0, 0, 16'h5555};

        rst = 1'b1; start = 1'b0; seed = 8'h00;
        tick(3);
        check("rst_chal", chal, 0);
        check("rst_pulse", pulse, 0);
        check("rst_puf_reset", preset, 1);
        check("rst_resp", resp, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick(2);

        for (int i = 0; i < 6; i++)
            run(vecs[i].seed, vecs[i].mode, vecs[i].delay, 1'b0,
                32'(vecs[i].exp_resp), NBITS * (2 * SETTLE + 2 + vecs[i].delay) + 1);

        // Reset during the 5th FIRE abandons the run.
        v0 = vcount; r0 = rises;
        mode_v = 0; delay_v = 1; seed_v = 8'h11;
        pulse_start(8'h11);
        for (int k = 0; k < 500 && rises - r0 < 5; k++) tick(1);
        check("midrun_pulse", pulse, 1);
        rst = 1'b1;
        #1;
        check("midrun_rst_chal", chal, 0);
        check("midrun_rst_pulse", pulse, 0);
        check("midrun_rst_puf_reset", preset, 1);
        check("midrun_rst_resp", resp, 0);
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_valid", valid, 0);
        tick(2);
        rst = 1'b0;
        tick(5);
        check("midrun_no_valid", vcount - v0, 0);
        check("post_rst_idle", busy, 0);
        run(8'h10, 0, 0, 1'b0, 32'hAAAA, NBITS * (2 * SETTLE + 2) + 1);

        // Start while busy is neither honoured nor queued.
        v0 = vcount;
        mode_v = 0; delay_v = 0; seed_v = 8'h10;
        pulse_start(8'h10);
        tick(30);
        pulse_start(8'h55);
        tick(40);
        seed = 8'h77; start = 1'b1;
        tick(5);
        start = 1'b0;
        for (int k = 0; k < 3000 && vcount == v0; k++) tick(1);
        tick(200);
        check("busy_start_valids", vcount - v0, 1);
        check("busy_start_resp", resp, 32'hAAAA);
        check("busy_start_idle", busy, 0);

`ifdef PUF_TIMEOUT_EN
        run(8'h10, 0, 0, 1'b1, 32'hAAA2, 15 * (2 * SETTLE + 2) + 2 * SETTLE + 64 + 1 + 1);
        check("timeout_set", tmo, 1);
        run(8'h10, 0, 0, 1'b0, 32'hAAAA, NBITS * (2 * SETTLE + 2) + 1);
        check("timeout_cleared", tmo, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
